ua_receive: RTL and testbench

UA_RECEIVE -- requirements
Module: ua_receive

---
 rtl/ua_receive.sv | 85 ++++++++
 tb/tb_ua_receive.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/ua_receive.sv
// ua_receive: 8N1 UART receiver with a valid/ready byte output and one-cycle
// framing-error and overrun pulses.
`timescale 1ns/1ps
`ifndef LOG2
`define LOG2(x) $clog2(x)
`endif
module ua_receive #(
  parameter int ClockFreq = 100_000_000,
  parameter int BaudRate  = 115_200
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       SIn,
  output logic [7:0] DataOut,
  output logic       DataOutValid,
  input  logic       DataOutReady,
  output logic       FramingError,
  output logic       Overrun
);
  localparam int SymbolEdgeTime = ClockFreq / BaudRate;
  localparam int SampleTime = SymbolEdgeTime / 2;
  localparam int CW = `LOG2(SymbolEdgeTime);
  localparam logic [2:0] IDLE = 3'd0, START = 3'd1, DATA = 3'd2, STOP = 3'd3, BREAK = 3'd4;
  logic [1:0] sync;
  logic sin_s;
  logic [2:0] state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] shreg;
  logic half_end, bit_end, cnt_clr, byte_done, frame_bad, take;
  assign sin_s = sync[1];
  assign half_end = cnt == CW'(SampleTime - 1);
  assign bit_end = cnt == CW'(SymbolEdgeTime - 1);
  assign cnt_clr = state == IDLE || state == BREAK || (state == START && half_end) || bit_end;
  assign byte_done = state == STOP && bit_end && sin_s;
  assign frame_bad = state == STOP && bit_end && !sin_s;
  assign take = !DataOutValid || DataOutReady;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = sin_s ? IDLE : START;
      START:   state_n = half_end ? (sin_s ? IDLE : DATA) : START;
      DATA:    state_n = (bit_end && idx == 3'd7) ? STOP : DATA;
      STOP:    state_n = bit_end ? (sin_s ? IDLE : BREAK) : STOP;
      BREAK:   state_n = sin_s ? IDLE : BREAK;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      sync <= 2'b11;
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
    end else begin
      sync <= {sync[0], SIn};
      state <= state_n;
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state == START && half_end) idx <= '0;
      if (state == DATA && bit_end) begin
        shreg[idx] <= sin_s;
        idx <= idx + 3'd1;
      end
    end
  end
  // A completed byte is only accepted when the output slot is free or being consumed.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      DataOut <= 8'h00;
      DataOutValid <= 1'b0;
      FramingError <= 1'b0;
      Overrun <= 1'b0;
    end else begin
      FramingError <= frame_bad;
      Overrun <= byte_done && !take;
      if (byte_done && take) begin
        DataOut <= shreg;
        DataOutValid <= 1'b1;
      end else if (DataOutValid && DataOutReady) begin
        DataOutValid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_ua_receive.sv
// tb_ua_receive: table-driven frames plus hand sequences, received bytes
// checked against a scoreboard queue of expected bytes.
`timescale 1ns/1ps
module tb_ua_receive;
  logic Clock = 1'b0, Reset = 1'b1, SIn = 1'b1, DataOutReady = 1'b1;
  logic [7:0] DataOut;
  logic DataOutValid, FramingError, Overrun;
  int checks = 0, failures = 0, fe_cnt = 0, ov_cnt = 0, v_cnt = 0;
  int fe0, ov0, v0;
  logic [7:0] exp_q[$];
  typedef struct {
    logic [7:0] data;
    logic stop;
    logic ready;
    int fe;
    int ov;
    int vc;
  } vec_t;
  vec_t vecs[5];

  ua_receive #(.ClockFreq(1_000_000), .BaudRate(100_000)) dut (
    .Clock(Clock), .Reset(Reset), .SIn(SIn), .DataOut(DataOut),
    .DataOutValid(DataOutValid), .DataOutReady(DataOutReady),
    .FramingError(FramingError), .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic stop, input int nbits);
    logic [9:0] f;
    f = {stop, d, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      SIn = f[i];
      repeat (10) @(posedge Clock);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge Clock);
    #1;
  endtask

  task automatic snap();
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    v0 = v_cnt;
  endtask

  always @(negedge Clock) begin
    if (!Reset) begin
      if (DataOutValid) v_cnt++;
      if (FramingError) fe_cnt++;
      if (Overrun) ov_cnt++;
      if (FramingError || Overrun) chk("fe_ov_exclusive", {31'd0, FramingError & Overrun}, 0);
      if (DataOutValid && DataOutReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_byte: got %0h expected none", DataOut);
        end else begin
          chk("scoreboard_byte", {24'd0, DataOut}, {24'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1'b1, 0, 0, 1};
    vecs[1] = '{8'h3C, 1'b0, 1'b1, 1, 0, 0};
    vecs[2] = '{8'h11, 1'b1, 1'b1, 0, 0, 1};
    vecs[3] = '{8'h5A, 1'b1, 1'b1, 0, 0, 1};
    vecs[4] = '{8'hC3, 1'b1, 1'b1, 0, 0, 1};
    idle(3);
    chk("reset_dout", {24'd0, DataOut}, 0);
    chk("reset_valid", {31'd0, DataOutValid}, 0);
    chk("reset_fe", {31'd0, FramingError}, 0);
    chk("reset_ov", {31'd0, Overrun}, 0);
    Reset = 1'b0;
    idle(5);
    snap();
    SIn = 1'b0;
    idle(3);
    SIn = 1'b1;
    idle(20);
    chk("false_start_valid", v_cnt - v0, 0);
    chk("false_start_fe", fe_cnt - fe0, 0);
    foreach (vecs[k]) begin
      DataOutReady = vecs[k].ready;
      snap();
      if (vecs[k].vc > 0) exp_q.push_back(vecs[k].data);
      send(vecs[k].data, vecs[k].stop, 10);
      if (!vecs[k].stop) begin
        idle(30);
        SIn = 1'b1;
      end
      idle(10);
      chk("row_fe", fe_cnt - fe0, vecs[k].fe);
      chk("row_ov", ov_cnt - ov0, vecs[k].ov);
      chk("row_valid_cycles", v_cnt - v0, vecs[k].vc);
      if (vecs[k].vc > 0) chk("row_dout", {24'd0, DataOut}, {24'd0, vecs[k].data});
    end
    DataOutReady = 1'b0;
    snap();
    exp_q.push_back(8'h01);
    send(8'h01, 1'b1, 10);
    send(8'h02, 1'b1, 10);
    idle(5);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    chk("ovr_fe", fe_cnt - fe0, 0);
    chk("ovr_dout_held", {24'd0, DataOut}, 8'h01);
    chk("ovr_valid_held", {31'd0, DataOutValid}, 1);
    DataOutReady = 1'b1;
    idle(1);
    chk("ovr_valid_cleared", {31'd0, DataOutValid}, 0);
    send(8'h55, 1'b1, 5);
    SIn = 1'b1;
    idle(5);
    Reset = 1'b1;
    idle(3);
    chk("midreset_dout", {24'd0, DataOut}, 0);
    chk("midreset_valid", {31'd0, DataOutValid}, 0);
    chk("midreset_fe", {31'd0, FramingError}, 0);
    chk("midreset_ov", {31'd0, Overrun}, 0);
    Reset = 1'b0;
    idle(5);
    snap();
    exp_q.push_back(8'h7E);
    send(8'h7E, 1'b1, 10);
    idle(10);
    chk("after_reset_dout", {24'd0, DataOut}, 8'h7E);
    chk("after_reset_fe", fe_cnt - fe0, 0);
    chk("after_reset_ov", ov_cnt - ov0, 0);
    chk("after_reset_valid_cycles", v_cnt - v0, 1);
    snap();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send(8'h00, 1'b1, 10);
    send(8'hFF, 1'b1, 10);
    idle(10);
    chk("gapless_valid_cycles", v_cnt - v0, 2);
    chk("gapless_fe", fe_cnt - fe0, 0);
    chk("gapless_ov", ov_cnt - ov0, 0);
    chk("gapless_dout", {24'd0, DataOut}, 8'hFF);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
